// File: rtl/lut_interp_pipe_pkg.sv
// Shared widths, rounding-mode constants and the offset-binary index helper
// for the LUT interpolator.
package interp_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int FRAC_W_DEF    = 4;
    localparam int ROUND_FLOOR   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Drop the fraction bits and flip the sign bit so the most negative input
    // lands on entry 0; data arrives sign-extended to 32 bits.
    function automatic logic [31:0] interp_idx(input logic [31:0] data,
                                               input int          data_w,
                                               input int          frac_w);
        logic [31:0] mask;
        mask = (32'd1 << (data_w - frac_w)) - 32'd1;
        return ((data >> frac_w) ^ (32'd1 << (data_w - frac_w - 1))) & mask;
    endfunction

endpackage

// File: rtl/lut_interp_pipe_table.sv
// Breakpoint register file: one write port, registered dual read of idx and
// idx+1 (clamped at the top entry). The read registers form pipeline stage 1.
module lut_interp_table
    import interp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = DATA_W_DEF - FRAC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic signed [DATA_W-1:0] wdata,
    input  logic                     en,
    input  logic [ADDR_W-1:0]        raddr,
    output logic signed [DATA_W-1:0] rd_base,
    output logic signed [DATA_W-1:0] rd_next
);

    localparam int DEPTH = 1 << ADDR_W;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]        naddr;

    assign naddr = (raddr == {ADDR_W{1'b1}}) ? raddr : raddr + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the pre-write contents on a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_base <= '0;
            rd_next <= '0;
        end else if (en) begin
            rd_base <= mem[raddr];
            rd_next <= mem[naddr];
        end
    end

endmodule

// File: rtl/lut_interp_pipe.sv
// Three-stage piecewise-linear interpolator over a loadable breakpoint table,
// with a single global stall driven by the output handshake.
module lut_interp_pipe
    import interp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ROUND  = ROUND_FLOOR,
    parameter int ADDR_W = DATA_W - FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    input  logic                     tbl_we,
    input  logic [ADDR_W-1:0]        tbl_addr,
    input  logic signed [DATA_W-1:0] tbl_data
);

    localparam int STAGES = 3;
    localparam int P_W    = DATA_W + FRAC_W + 2;
    localparam logic signed [P_W-1:0] RND =
        (ROUND == ROUND_HALF_UP) ? (P_W'(1) <<< (FRAC_W - 1)) : '0;

    logic                     en;
    logic [STAGES:1]          vld_pipe;
    logic [ADDR_W-1:0]        idx;
    logic signed [DATA_W-1:0] s1_base, s1_next;
    logic [FRAC_W-1:0]        s1_frac;
    logic signed [DATA_W:0]   diff;
    logic signed [P_W-1:0]    prod;
    logic signed [P_W-1:0]    s2_prod;
    logic signed [DATA_W-1:0] s2_base;
    logic signed [P_W-1:0]    shifted;
    logic signed [DATA_W-1:0] res;
    logic                     unused_hi;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];
    assign idx       = ADDR_W'(interp_idx(32'(in_data), DATA_W, FRAC_W));

    lut_interp_table #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_table (
        .clk    (clk),
        .rst    (rst),
        .we     (tbl_we),
        .waddr  (tbl_addr),
        .wdata  (tbl_data),
        .en     (en),
        .raddr  (idx),
        .rd_base(s1_base),
        .rd_next(s1_next)
    );

    // One extra bit on diff and a zero-extended fraction keep the product exact.
    assign diff = {s1_next[DATA_W-1], s1_next} - {s1_base[DATA_W-1], s1_base};
    assign prod = P_W'(diff) * P_W'($signed({1'b0, s1_frac}));

    assign shifted   = (s2_prod + RND) >>> FRAC_W;
    assign res       = s2_base + shifted[DATA_W-1:0];
    assign unused_hi = ^shifted[P_W-1:DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_frac  <= '0;
            s2_prod  <= '0;
            s2_base  <= '0;
            out_data <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_frac  <= in_data[FRAC_W-1:0];
            s2_prod  <= prod;
            s2_base  <= s1_base;
            if (vld_pipe[2]) out_data <= res;
        end
    end

endmodule

// File: tb/tb_lut_interp_pipe.sv
// Randomized and directed bench for lut_interp_pipe: floor and round-half-up
// instances share stimulus and are scored against an arithmetic table model.
module tb_lut_interp_pipe;

    logic       clk = 0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       tbl_we;
    logic [3:0] tbl_addr;
    logic [7:0] tbl_data;

    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;

    int n_chk = 0;
    int n_err = 0;

    typedef struct { int e0; int e1; } exp_t;
    exp_t sbq[$];
    int   m_tbl[16];
    bit   held_v;
    int   held_d0, held_d1;
    bit   saw_stall;

    always #5 clk = ~clk;

    lut_interp_pipe #(.DATA_W(8), .FRAC_W(4), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    lut_interp_pipe #(.DATA_W(8), .FRAC_W(4), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: value v in [-128,127] sits at offset v+128 from the bottom of
    // a 16-segment ramp, each segment 16 steps wide.
    function automatic int model(input int v, input bit rnd);
        int u, i, f, b, n, p;
        u = v + 128;
        i = u / 16;
        f = u % 16;
        b = m_tbl[i];
        n = (i == 15) ? b : m_tbl[i + 1];
        p = (n - b) * f;
        if (rnd) p = p + 8;
        return b + (p >>> 4);
    endfunction

    function automatic int s8(input logic [7:0] x);
        return int'($signed(x));
    endfunction

    // Inputs change just after posedge, so the negedge view decides the next edge.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            for (int i = 0; i < 16; i++) m_tbl[i] = 0;
            held_v = 0;
        end else begin
            if (held_v) begin
                chk("hold_valid", int'(out_valid0), 1);
                chk("hold_data0", s8(out_data0), held_d0);
                chk("hold_data1", s8(out_data1), held_d1);
                held_v = 0;
            end
            if (out_valid0) begin
                if (out_ready) begin
                    if (sbq.size() == 0) chk("spurious_out", 1, 0);
                    else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("out_floor", s8(out_data0), e.e0);
                        chk("out_round", s8(out_data1), e.e1);
                    end
                end else begin
                    held_v  = 1;
                    held_d0 = s8(out_data0);
                    held_d1 = s8(out_data1);
                end
            end
            if (!in_ready0) saw_stall = 1;
            if (in_valid && in_ready0) begin
                exp_t e;
                e.e0 = model(s8(in_data), 0);
                e.e1 = model(s8(in_data), 1);
                sbq.push_back(e);
            end
            if (tbl_we) m_tbl[tbl_addr] = s8(tbl_data);
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        tbl_we   = 1;
        tbl_addr = 4'(a);
        tbl_data = 8'(d);
        @(posedge clk);
        #1;
        tbl_we = 0;
    endtask

    // Must be entered just after a posedge; leaves just after the accepting edge.
    task automatic send(input logic [7:0] d);
        int n;
        in_valid = 1;
        in_data  = d;
        @(negedge clk);
        n = 0;
        while (!in_ready0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    // Single sample with the exact 3-cycle latency checked on the floor instance.
    task automatic run1(input string tag, input logic [7:0] d, input int e0, input int e1);
        align();
        out_ready = 1;
        in_valid  = 1;
        in_data   = d;
        @(posedge clk);
        #1;
        in_valid = 0;
        @(negedge clk);
        chk({tag, "_lat1"}, int'(out_valid0), 0);
        @(negedge clk);
        chk({tag, "_lat2"}, int'(out_valid0), 0);
        @(negedge clk);
        chk({tag, "_valid"}, int'(out_valid0), 1);
        chk({tag, "_floor"}, s8(out_data0), e0);
        chk({tag, "_round"}, s8(out_data1), e1);
    endtask

    task automatic drain();
        int n;
        out_ready = 1;
        in_valid  = 0;
        n = 0;
        while ((sbq.size() != 0 || out_valid0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 0; out_ready = 1;
        tbl_we = 0; tbl_addr = 0; tbl_data = 0; saw_stall = 0;
        #1;
        chk("rst_valid", int'(out_valid0), 0);
        chk("rst_data", s8(out_data0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready0), 1);

        wr(8, 16); wr(9, 32);
        run1("pos_slope", 8'h08, 24, 24);
        wr(8, 32); wr(9, 16);
        run1("neg_slope", 8'h04, 28, 28);
        run1("frac_zero", 8'h00, 32, 32);
        wr(8, 0); wr(9, 1);
        run1("round_pos", 8'h08, 0, 1);
        wr(9, -1);
        run1("round_neg", 8'h08, -1, 0);
        wr(15, 100);
        run1("clamp_top", 8'h7F, 100, 100);
        wr(0, -50); wr(1, -50);
        run1("bottom", 8'h80, -50, -50);

        // Back-to-back stream with a four-cycle downstream stall.
        align();
        saw_stall = 0;
        fork
            begin
                for (int c = 0; c < 24; c++) begin
                    out_ready = !(c >= 4 && c <= 7);
                    @(posedge clk);
                    #1;
                end
            end
            begin
                for (int k = 0; k < 6; k++) send(8'($urandom));
            end
        join
        drain();
        chk("bp_stall_seen", int'(saw_stall), 1);

        // Random traffic with concurrent table writes.
        align();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            tbl_we    = ($urandom % 5) == 0;
            tbl_addr  = 4'($urandom);
            tbl_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        tbl_we = 0;
        drain();

        // Reset with samples in flight.
        wr(5, 70); wr(6, -70);
        align();
        out_ready = 1;
        send(8'hD3); send(8'hD9); send(8'hE1);
        rst = 1;
        #1;
        chk("midrst_valid", int'(out_valid0), 0);
        chk("midrst_data", s8(out_data0), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", int'(in_ready0), 1);
        run1("post_rst", 8'hD9, 0, 0);
        run1("post_rst_top", 8'h7F, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lut_interp_pipe.md
Name: lut_interp_pipe

Overview:
- Pipelined, parametrised successor to the combinational activation-function interpolator. It is used by neural-network layer `func` blocks.
- Holds a loadable breakpoint table internally. It splits each signed input into a table index and a fractional remainder.
- Output is `base + ((next - base) * frac) >> FRAC_W`, with optional rounding.
- Fully pipelined with valid/ready handshakes on both sides.

Parameters:
- `DATA_W`, default 8: width of input sample, table entries and output (signed).
- `FRAC_W`, default 4: number of low input bits used as the unsigned interpolation fraction. Requires 1 <= `FRAC_W` < `DATA_W`.
- `ROUND`, default 0: 0 = floor (arithmetic shift); 1 = round-half-up (add `2^(FRAC_W-1)` before the shift).
- `ADDR_W`, derived as `DATA_W - FRAC_W`: table index width. Table depth is `2^ADDR_W`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_data`  in  `DATA_W`  signed input sample.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  `DATA_W`  signed interpolated result.
- `tbl_we`  in  1  table write enable.
- `tbl_addr`  in  `ADDR_W`  table write address.
- `tbl_data`  in  `DATA_W`  signed table write data.

Behaviour:
- Reset (asynchronous, active-high):
  - All stage valid flags clear, so `out_valid=0` and `out_data=0`.
  - All table entries clear to 0.
  - `in_ready=1` from the first cycle after reset deasserts.
- Index mapping:
  - `idx = {~in_data[DATA_W-1], in_data[DATA_W-2:FRAC_W]}` (offset binary), so the most negative input maps to entry 0.
  - `frac = in_data[FRAC_W-1:0]`, unsigned, range 0..`2^FRAC_W-1`.
- Neighbour lookup:
  - `base = tbl[idx]`.
  - `next = tbl[idx+1]`, except at `idx = 2^ADDR_W-1`, where `next = base` (clamp, no wrap).
- Pipeline: three stages.
  - S1: register `idx` and `frac`, read `base` and `next` from the table.
  - S2: compute `diff = next - base` at `DATA_W+1` bits signed; compute `prod = diff * $signed({1'b0,frac})` at `DATA_W+FRAC_W+2` bits.
  - S3: add the rounding constant if `ROUND=1`, arithmetic shift right by `FRAC_W`, add `base`, truncate to `DATA_W`.
  - The result always lies between `base` and `next` inclusive, so truncation never overflows.
  - Latency is 3 cycles from accepted input to `out_valid` when there is no backpressure. Throughput is 1 sample per cycle.
- Handshake:
  - Global advance `en = !out_valid | out_ready`; `in_ready = en`.
  - A transfer occurs on `valid & ready`. When `en=0`, every stage holds its value.
  - `out_data` is stable while `out_valid & !out_ready`.
  - Bubbles (invalid stages) propagate and do not block accepted samples.
- Table write:
  - Writes occur at the clock edge when `tbl_we=1`, regardless of pipeline state.
  - An S1 read on the same edge as a write to the same address returns the old value.
  - Samples already past S1 are unaffected by later writes.
- Reset mid-operation: all in-flight samples are discarded with no output, and the table is cleared.

Decomposition:
- Shared package `interp_pkg` holds:
  - default widths (`DATA_W_DEF=8`, `FRAC_W_DEF=4`);
  - constants `ROUND_FLOOR=0`, `ROUND_HALF_UP=1`;
  - function `interp_idx()` for the offset-binary index.
- One sub-module, `lut_interp_table`: the `2^ADDR_W`-entry register file with one write port and a dual registered read (`idx`, `idx+1` with clamp).
- Pipeline and arithmetic stay in the top module.

Test Plan:
- Default parameters; load `tbl[8]=16`, `tbl[9]=32`; send `in_data=8'h08` (`idx=8`, `frac=8`) -> `out_data=24`, `out_valid` 3 cycles after acceptance.
- Negative slope: `tbl[8]=32`, `tbl[9]=16`, `in_data=8'h04` -> `32 + ((-16*4)>>4) = 28`. Then `in_data=8'h00` -> exactly 32.
- Rounding: `tbl[8]=0`, `tbl[9]=1`, `in_data=8'h08` -> 0 with `ROUND=0`, 1 with `ROUND=1`. Negative case: `tbl[8]=0`, `tbl[9]=-1`, `in_data=8'h08` -> -1 with floor, 0 with round-half-up.
- Boundaries:
  - `tbl[15]=100`, `in_data=8'h7F` -> 100 (clamp, `next=base`).
  - `tbl[0]=-50`, `tbl[1]=-50`, `in_data=8'h80` -> -50.
- Backpressure: stream 6 back-to-back samples with `out_ready` low for cycles 4..7 -> `in_ready` drops, no sample is lost or duplicated, and `out_data` holds during the stall.
- Assert `rst` with 3 samples in flight -> `out_valid=0` immediately. After release, the table reads 0 and a new sample returns 0 after 3 cycles.
